// File: rtl/ep_arb_if.sv
// ep_arb_if: endpoint channel handshake, per-client handshake and client TRN tx buses for ep_arb.
// master is the arbiter side; slave is the channel/client side.
interface ep_arb_if #(
    parameter int unsigned NCH = 3
);
    logic               chn_trn;
    logic               chn_drvn;
    logic               chn_reqep;

    logic [NCH-1:0]     cl_reqep;
    logic [NCH-1:0]     cl_drvn;
    logic [NCH-1:0]     cl_trn;

    logic [NCH*64-1:0]  cl_trn_td;
    logic [NCH*8-1:0]   cl_trn_trem_n;
    logic [NCH-1:0]     cl_trn_tsof_n;
    logic [NCH-1:0]     cl_trn_teof_n;
    logic [NCH-1:0]     cl_trn_tsrc_rdy_n;

    logic [63:0]        trn_td;
    logic [7:0]         trn_trem_n;
    logic               trn_tsof_n;
    logic               trn_teof_n;
    logic               trn_tsrc_rdy_n;

    logic               wdog_to;

    modport master (
        input  chn_trn,
        input  cl_reqep,
        input  cl_drvn,
        input  cl_trn_td,
        input  cl_trn_trem_n,
        input  cl_trn_tsof_n,
        input  cl_trn_teof_n,
        input  cl_trn_tsrc_rdy_n,
        output chn_drvn,
        output chn_reqep,
        output cl_trn,
        output trn_td,
        output trn_trem_n,
        output trn_tsof_n,
        output trn_teof_n,
        output trn_tsrc_rdy_n,
        output wdog_to
    );

    modport slave (
        output chn_trn,
        output cl_reqep,
        output cl_drvn,
        output cl_trn_td,
        output cl_trn_trem_n,
        output cl_trn_tsof_n,
        output cl_trn_teof_n,
        output cl_trn_tsrc_rdy_n,
        input  chn_drvn,
        input  chn_reqep,
        input  cl_trn,
        input  trn_td,
        input  trn_trem_n,
        input  trn_tsof_n,
        input  trn_teof_n,
        input  trn_tsrc_rdy_n,
        input  wdog_to
    );
endinterface

// File: rtl/ep_arb.sv
// ep_arb: shares one PCIe endpoint TRN tx channel among NCH clients and muxes the granted bus.
// Define EP_ARB_WDOG_EN to revoke grants whose client does not start driving within GRANT_TO cycles.
module ep_arb #(
    parameter int unsigned    NCH      = 3,
    parameter int unsigned    MODE     = 0,
    parameter logic [NCH-1:0] REQ_MASK = '1,
    parameter int unsigned    GRANT_TO = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    ep_arb_if.master bus
);
    localparam int unsigned WW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StBusy,
        StRelease
    } state_e;

    state_e         state_q, state_d;
    logic [WW-1:0]  w_q, w_d;
    logic [WW-1:0]  ptr_q, ptr_d;
    logic [NCH-1:0] cl_trn_q, cl_trn_d;
    logic           chn_reqep_q, chn_reqep_d;
    logic           ready_q;

    logic [NCH-1:0] eligible;
    logic           any_elig;
    logic [WW-1:0]  win;
    logic           found;
    int             idx;
    logic           win_drvn;
    logic           wdog_fire;

    // Unmasked clients have no request line and always compete.
    assign eligible = bus.cl_reqep | ~REQ_MASK;
    assign any_elig = |eligible;
    assign win_drvn = bus.cl_drvn[w_q];

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        if (MODE == 1) begin
            for (int i = 0; i < int'(NCH); i++) begin
                if (!found && eligible[i]) begin
                    win   = WW'(i);
                    found = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < int'(NCH); k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= int'(NCH)) begin
                    idx = idx - int'(NCH);
                end
                if (!found && eligible[idx]) begin
                    win   = WW'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        ptr_d    = ptr_q;
        cl_trn_d = cl_trn_q;
        unique case (state_q)
            StIdle: begin
                // ready_q holds off arbitration for the first edge after reset.
                if (ready_q && bus.chn_trn && any_elig) begin
                    w_d      = win;
                    cl_trn_d = {{(NCH-1){1'b0}}, 1'b1} << win;
                    state_d  = StGrant;
                end
            end
            StGrant: begin
                if (win_drvn) begin
                    state_d = StBusy;
                end else if (wdog_fire || !bus.chn_trn) begin
                    cl_trn_d = '0;
                    state_d  = StRelease;
                end
            end
            StBusy: begin
                if (!win_drvn) begin
                    cl_trn_d = '0;
                    state_d  = StRelease;
                end
            end
            StRelease: begin
                ptr_d   = (w_q == WW'(NCH - 1)) ? '0 : w_q + 1'b1;
                state_d = StIdle;
            end
            default: begin
                cl_trn_d = '0;
                state_d  = StIdle;
            end
        endcase
        chn_reqep_d = (state_d == StIdle) && any_elig;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            w_q         <= '0;
            ptr_q       <= '0;
            cl_trn_q    <= '0;
            chn_reqep_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            ptr_q       <= ptr_d;
            cl_trn_q    <= cl_trn_d;
            chn_reqep_q <= chn_reqep_d;
            ready_q     <= 1'b1;
        end
    end

`ifdef EP_ARB_WDOG_EN
    localparam int unsigned CW = (GRANT_TO > 1) ? $clog2(GRANT_TO) : 1;

    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          wdog_q, wdog_d;

    assign wdog_fire = (state_q == StGrant) && !win_drvn && (wcnt_q == CW'(GRANT_TO - 1));

    always_comb begin
        wcnt_d = wcnt_q;
        wdog_d = wdog_fire;
        if (state_q == StIdle && state_d == StGrant) begin
            wcnt_d = '0;
        end else if (state_q == StGrant) begin
            wcnt_d = wcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q <= '0;
            wdog_q <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            wdog_q <= wdog_d;
        end
    end

    assign bus.wdog_to = wdog_q;
`else
    assign wdog_fire   = 1'b0;
    assign bus.wdog_to = 1'b0;
`endif

    assign bus.cl_trn    = cl_trn_q;
    assign bus.chn_reqep = chn_reqep_q;
    assign bus.chn_drvn  = (state_q != StIdle);

    always_comb begin
        bus.trn_td         = '0;
        bus.trn_trem_n     = '1;
        bus.trn_tsof_n     = 1'b1;
        bus.trn_teof_n     = 1'b1;
        bus.trn_tsrc_rdy_n = 1'b1;
        if (cl_trn_q[w_q]) begin
            bus.trn_td         = bus.cl_trn_td[w_q*64 +: 64];
            bus.trn_trem_n     = bus.cl_trn_trem_n[w_q*8 +: 8];
            bus.trn_tsof_n     = bus.cl_trn_tsof_n[w_q];
            bus.trn_teof_n     = bus.cl_trn_teof_n[w_q];
            bus.trn_tsrc_rdy_n = bus.cl_trn_tsrc_rdy_n[w_q];
        end
    end

`ifndef SYNTHESIS
    a_trn_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(cl_trn_q));
    a_trn_is_w: assert property (@(posedge clk) disable iff (!rst_n)
        (cl_trn_q != '0) |-> cl_trn_q[w_q]);
`endif

endmodule
